// File: rtl/mips_dbg_pkg.sv
// Debug-sequencer state encoding shared by the run controller and the VGA debug view.
package mips_dbg_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2,
    ST_BRK  = 2'd3
  } run_state_e;

  localparam int unsigned StepCtrW = 8;

  function automatic logic is_stopped(run_state_e s);
    return (s == ST_HALT) || (s == ST_BRK);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous button level plus rising-edge detect.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/mips_run_ctrl.sv
// Run/halt/step/breakpoint sequencer owning the MIPS pipeline enable, plus the
// interrupt pulse gate and enabled-cycle / completed-step statistics.
module mips_run_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        debug_en,
  input  logic        step_btn,
  input  logic        irq_btn,
  input  logic        brk_en,
  input  logic [31:0] brk_pc,
  input  logic [31:0] if_pc,
  output logic        cpu_en,
  output logic        irq_pulse,
  output logic        halted,
  output logic        brk_hit,
  output logic [1:0]  state,
  output logic [31:0] cycle_cnt,
  output logic [15:0] step_cnt
);

  localparam logic [StepCtrW-1:0] StepLast = StepCtrW'(STEP_CYCLES);

  logic step_rise, irq_rise;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (step_btn),
    .rise_o (step_rise)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (irq_btn),
    .rise_o (irq_rise)
  );

  run_state_e          state_q, state_d;
  logic [StepCtrW-1:0] step_ctr_q, step_ctr_d;
  logic                armed_q, armed_d;
  logic                pending_q, pending_d;
  logic                halted_q, halted_d;
  logic                brk_hit_q, brk_hit_d;
  logic [31:0]         cycle_cnt_q, cycle_cnt_d;
  logic [15:0]         step_cnt_q, step_cnt_d;
  logic                match, step_done, entering;

  always_comb begin
    // Combinational match freezes the pipeline with brk_pc still held in IF.
    match     = (state_q == ST_RUN) & brk_en & armed_q & (if_pc == brk_pc);
    cpu_en    = ((state_q == ST_RUN) | (state_q == ST_STEP)) & ~match;
    irq_pulse = pending_q & cpu_en;
    step_done = (state_q == ST_STEP) && ((step_ctr_q + 8'd1) == StepLast);

    state_d = state_q;
    unique case (state_q)
      ST_HALT, ST_BRK: begin
        if (!debug_en)      state_d = ST_RUN;
        else if (step_rise) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (match)         state_d = ST_BRK;
        else if (debug_en) state_d = ST_HALT;
      end
      ST_STEP: begin
        if (step_done) state_d = ST_HALT;
      end
    endcase

    step_ctr_d = (state_q == ST_STEP) ? step_ctr_q + 8'd1 : '0;

    // Disarm on entry so resuming/stepping from brk_pc cannot re-trigger at once.
    entering = (state_d != state_q) && ((state_d == ST_RUN) || (state_d == ST_STEP));
    if (entering)    armed_d = 1'b0;
    else if (cpu_en) armed_d = 1'b1;
    else             armed_d = armed_q;

    pending_d   = pending_q ? ~irq_pulse : irq_rise;
    cycle_cnt_d = cycle_cnt_q + {31'd0, cpu_en};
    step_cnt_d  = step_cnt_q + {15'd0, step_done};
    halted_d    = is_stopped(state_d);
    brk_hit_d   = (state_d == ST_BRK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HALT;
      step_ctr_q  <= '0;
      armed_q     <= 1'b0;
      pending_q   <= 1'b0;
      halted_q    <= 1'b1;
      brk_hit_q   <= 1'b0;
      cycle_cnt_q <= '0;
      step_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      step_ctr_q  <= step_ctr_d;
      armed_q     <= armed_d;
      pending_q   <= pending_d;
      halted_q    <= halted_d;
      brk_hit_q   <= brk_hit_d;
      cycle_cnt_q <= cycle_cnt_d;
      step_cnt_q  <= step_cnt_d;
    end
  end

  assign state     = state_q;
  assign halted    = halted_q;
  assign brk_hit   = brk_hit_q;
  assign cycle_cnt = cycle_cnt_q;
  assign step_cnt  = step_cnt_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: two instances (1-cycle and 8-cycle steps) on shared stimulus,
// checked every cycle against a behavioural model, plus directed scenario checks.
module tb_mips_run_ctrl;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned StepA      = 1;
  localparam int unsigned StepB      = 8;
  localparam int MRun = 0, MHalt = 1, MStep = 2, MBrk = 3;

  logic        clk = 1'b0;
  logic        rst, debug_en, step_btn, irq_btn, brk_en;
  logic [31:0] brk_pc, if_pc;

  logic        cpu_en    [2];
  logic        irq_pulse [2];
  logic        halted    [2];
  logic        brk_hit   [2];
  logic [1:0]  state     [2];
  logic [31:0] cycle_cnt [2];
  logic [15:0] step_cnt  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mips_run_ctrl #(
      .STEP_CYCLES (g == 0 ? StepA : StepB),
      .SYNC_STAGES (SyncStages)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .debug_en  (debug_en),
      .step_btn  (step_btn),
      .irq_btn   (irq_btn),
      .brk_en    (brk_en),
      .brk_pc    (brk_pc),
      .if_pc     (if_pc),
      .cpu_en    (cpu_en[g]),
      .irq_pulse (irq_pulse[g]),
      .halted    (halted[g]),
      .brk_hit   (brk_hit[g]),
      .state     (state[g]),
      .cycle_cnt (cycle_cnt[g]),
      .step_cnt  (step_cnt[g])
    );
  end

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state, one set per instance.
  int          m_state [2];
  int          m_ctr   [2];
  bit          m_armed [2];
  bit          m_pend  [2];
  logic [31:0] m_cyc   [2];
  logic [15:0] m_stp   [2];
  int          step_len [2] = '{int'(StepA), int'(StepB)};
  bit          hs[$];
  bit          hi[$];

  // Raw samples taken at each edge since reset; the synchroniser shows sample n-S.
  function automatic bit rise_of(input bit q[$]);
    int n = q.size();
    int s = int'(SyncStages);
    bit a = (n >= s)     ? q[n-s]   : 1'b0;
    bit b = (n >= s + 1) ? q[n-s-1] : 1'b0;
    return a & ~b;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = MHalt; m_ctr[k] = 0; m_armed[k] = 0; m_pend[k] = 0;
      m_cyc[k] = '0; m_stp[k] = '0;
    end
    hs.delete();
    hi.delete();
  endtask

  task automatic model_cycle(input int k, input bit sr, input bit ir);
    bit hit, en, pulse, done;
    int nxt;
    hit   = (m_state[k] == MRun) && brk_en && m_armed[k] && (if_pc == brk_pc);
    en    = ((m_state[k] == MRun) || (m_state[k] == MStep)) && !hit;
    pulse = m_pend[k] && en;
    done  = (m_state[k] == MStep) && (m_ctr[k] + 1 == step_len[k]);
    check_eq($sformatf("state%0d", k), 32'(state[k]), 32'(m_state[k]));
    check_eq($sformatf("cpu_en%0d", k), 32'(cpu_en[k]), 32'(en));
    check_eq($sformatf("irq_pulse%0d", k), 32'(irq_pulse[k]), 32'(pulse));
    check_eq($sformatf("halted%0d", k), 32'(halted[k]),
             32'((m_state[k] == MHalt) || (m_state[k] == MBrk)));
    check_eq($sformatf("brk_hit%0d", k), 32'(brk_hit[k]), 32'(m_state[k] == MBrk));
    check_eq($sformatf("cycle_cnt%0d", k), cycle_cnt[k], m_cyc[k]);
    check_eq($sformatf("step_cnt%0d", k), 32'(step_cnt[k]), 32'(m_stp[k]));
    nxt = m_state[k];
    case (m_state[k])
      MHalt, MBrk: if (!debug_en) nxt = MRun; else if (sr) nxt = MStep;
      MRun:        if (hit) nxt = MBrk; else if (debug_en) nxt = MHalt;
      MStep:       if (done) nxt = MHalt;
      default:     nxt = MHalt;
    endcase
    m_ctr[k] = (m_state[k] == MStep) ? m_ctr[k] + 1 : 0;
    if (nxt != m_state[k] && (nxt == MRun || nxt == MStep)) m_armed[k] = 0;
    else if (en) m_armed[k] = 1;
    if (pulse) m_pend[k] = 0;
    else if (ir) m_pend[k] = 1;
    m_cyc[k]   = m_cyc[k] + 32'(en);
    m_stp[k]   = m_stp[k] + 16'(done);
    m_state[k] = nxt;
  endtask

  // One clock cycle: drive after the falling edge, check, then advance the model.
  task automatic tick(input bit d, input bit s, input bit i, input bit be,
                      input logic [31:0] bpc, input logic [31:0] pc);
    bit sr, ir;
    @(negedge clk);
    debug_en = d; step_btn = s; irq_btn = i; brk_en = be; brk_pc = bpc; if_pc = pc;
    #1;
    sr = rise_of(hs);
    ir = rise_of(hi);
    for (int k = 0; k < 2; k++) model_cycle(k, sr, ir);
    hs.push_back(s);
    hi.push_back(i);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rst_state%0d", k), 32'(state[k]), 32'(MHalt));
      check_eq($sformatf("rst_cpu_en%0d", k), 32'(cpu_en[k]), 32'd0);
      check_eq($sformatf("rst_irq%0d", k), 32'(irq_pulse[k]), 32'd0);
      check_eq($sformatf("rst_halted%0d", k), 32'(halted[k]), 32'd1);
      check_eq($sformatf("rst_brk%0d", k), 32'(brk_hit[k]), 32'd0);
      check_eq($sformatf("rst_cyc%0d", k), cycle_cnt[k], 32'd0);
      check_eq($sformatf("rst_stp%0d", k), 32'(step_cnt[k]), 32'd0);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          en_a, en_b, first, pl_a, pl_b, first_pl, stc, n;
    logic [31:0] pc;
    bit          rd, rs, ri, rbe;

    rst = 1'b0; debug_en = 1'b0; step_btn = 1'b0; irq_btn = 1'b0;
    brk_en = 1'b0; brk_pc = '0; if_pc = '0;
    do_reset();

    // Free run from reset.
    repeat (101) tick(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check_eq("run100_cycles", cycle_cnt[0], 32'd100);
    check_eq("run100_state", 32'(state[0]), 32'(MRun));

    // Halt, then a 5-cycle step press.
    repeat (4) tick(1, 0, 0, 0, 0, 0);
    en_a = 0; en_b = 0; first = -1;
    for (int t = 0; t < 16; t++) begin
      tick(1, t < 5, 0, 0, 0, 0);
      if (cpu_en[0]) begin
        en_a++;
        if (first < 0) first = t;
      end
      if (cpu_en[1]) en_b++;
    end
    check_eq("step_en_a", 32'(en_a), StepA);
    check_eq("step_en_b", 32'(en_b), StepB);
    check_eq("step_latency", 32'(first), SyncStages + 1);
    check_eq("step_cnt_a", 32'(step_cnt[0]), 32'd1);
    check_eq("step_state_a", 32'(state[0]), 32'(MHalt));

    // Breakpoint at 0x10 with IF advancing by 4; debug_en rises on the match cycle.
    pc = '0;
    for (int t = 0; t < 12; t++) begin
      tick(pc == 32'h10, 0, 0, 1, 32'h10, pc);
      if (cpu_en[0]) pc = pc + 32'd4;
    end
    check_eq("brk_pc_frozen", pc, 32'h10);
    check_eq("brk_state", 32'(state[0]), 32'(MBrk));
    check_eq("brk_hit_out", 32'(brk_hit[0]), 32'd1);
    en_a = 0;
    for (int t = 0; t < 16; t++) begin
      tick(1, t < 3, 0, 1, 32'h10, pc);
      if (cpu_en[0]) en_a++;
    end
    check_eq("brk_step_en", 32'(en_a), 32'd1);
    check_eq("brk_step_state", 32'(state[0]), 32'(MHalt));
    check_eq("brk_step_cnt", 32'(step_cnt[0]), 32'd2);

    // Interrupts while halted must wait, merged, for the next enabled cycle.
    pl_a = 0;
    for (int t = 0; t < 12; t++) begin
      tick(1, 0, (t == 1) || (t == 2) || (t == 6), 0, 0, 0);
      if (irq_pulse[0] || irq_pulse[1]) pl_a++;
    end
    check_eq("irq_halted", 32'(pl_a), 32'd0);
    pl_a = 0; pl_b = 0; first = -1; first_pl = -2;
    for (int t = 0; t < 16; t++) begin
      tick(1, t < 3, 0, 0, 0, 0);
      if (cpu_en[0] && first < 0) first = t;
      if (irq_pulse[0]) begin
        pl_a++;
        first_pl = t;
      end
      if (irq_pulse[1]) pl_b++;
    end
    check_eq("irq_pulses_a", 32'(pl_a), 32'd1);
    check_eq("irq_pulses_b", 32'(pl_b), 32'd1);
    check_eq("irq_first_en", 32'(first_pl), 32'(first));

    // Conflict: in BRK, debug_en falls on the same cycle the step edge is seen.
    tick(0, 0, 0, 1, 32'h10, 32'h10);
    tick(0, 0, 0, 1, 32'h10, 32'h10);
    repeat (3) tick(1, 0, 0, 1, 32'h10, 32'h10);
    check_eq("conf_brk", 32'(state[0]), 32'(MBrk));
    stc = int'(step_cnt[0]);
    tick(1, 1, 0, 1, 32'h10, 32'h10);
    tick(1, 1, 0, 1, 32'h10, 32'h10);
    tick(0, 1, 0, 1, 32'h10, 32'h10);
    @(posedge clk); #1;
    check_eq("conf_state", 32'(state[0]), 32'(MRun));
    check_eq("conf_step_cnt", 32'(step_cnt[0]), 32'(stc));

    // Reset during the third cycle of an 8-cycle step.
    repeat (4) tick(1, 0, 0, 0, 0, 0);
    n = 0;
    while (!(m_state[1] == MStep && m_ctr[1] == 2) && n < 20) begin
      tick(1, n < 5, 0, 0, 0, 0);
      n++;
    end
    check_eq("mid_step_reach", 32'(m_state[1] == MStep && m_ctr[1] == 2), 32'd1);
    tick(1, 1, 0, 0, 0, 0);
    check_eq("mid_step_en", 32'(cpu_en[1]), 32'd1);
    do_reset();
    repeat (3) tick(1, 0, 0, 0, 0, 0);

    // Random traffic against the model.
    rd = 1'b1; rs = 1'b0; ri = 1'b0; rbe = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      if ($urandom_range(15) == 0) rd = ~rd;
      if ($urandom_range(5) == 0)  rs = ~rs;
      if ($urandom_range(5) == 0)  ri = ~ri;
      if ($urandom_range(31) == 0) rbe = ~rbe;
      tick(rd, rs, ri, rbe, ($urandom_range(1) == 1) ? 32'h10 : 32'h14,
           32'($urandom_range(7)) * 32'd4);
      if ($urandom_range(499) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_run_ctrl.md
# mips_run_ctrl

Run/step/breakpoint sequencer for the 5-stage MIPS core. It owns the global pipeline enable (`cpu_en`) and decides when the core advances: free-running, halted, single-stepped from the board step button, or frozen on a PC breakpoint. It also forwards the board interrupt button to the core as a single pulse, delivered only while the pipeline is enabled. It sits between `btn_scan` outputs and the `mips` instance in the top level, in the `clk_cpu` domain.

## Interface
Parameters:
- `STEP_CYCLES`, default 1: `cpu_en` cycles per step request; legal range 1..255.
- `SYNC_STAGES`, default 2: flops in each button synchroniser; minimum 2.

Ports:
- `clk` in 1: CPU clock; every register is clocked on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `debug_en` in 1: 1 selects debug (halt/step) mode, 0 selects free run; synchronous level.
- `step_btn` in 1: step button level from `btn_scan`; asynchronous to `clk`.
- `irq_btn` in 1: interrupt button level; asynchronous to `clk`.
- `brk_en` in 1: enables the breakpoint compare.
- `brk_pc` in 32: breakpoint address.
- `if_pc` in 32: current IF-stage PC.
- `cpu_en` out 1: pipeline advance enable.
- `irq_pulse` out 1: one-cycle interrupt request to the core.
- `halted` out 1: high in HALT or BRK.
- `brk_hit` out 1: high in BRK.
- `state` out 2: current state code.
- `cycle_cnt` out 32: number of enabled cycles; wraps.
- `step_cnt` out 16: number of completed steps; wraps.

## Operation
- State codes: RUN=0, HALT=1, STEP=2, BRK=3.
- Each button passes through a `SYNC_STAGES` synchroniser. A rising edge is detected by comparing the synchroniser output against a registered copy of itself.

State transitions, evaluated every cycle:
- HALT, `debug_en`=0 → RUN.
- HALT, step edge → STEP.
- RUN, breakpoint match → BRK.
- RUN, `debug_en`=1 → HALT.
- STEP, step counter reaches `STEP_CYCLES` → HALT.
- BRK, `debug_en`=0 → RUN.
- BRK, step edge → STEP.

Breakpoint match:
- A match is `brk_en & armed & (if_pc == brk_pc)` while in RUN.
- `armed` clears on every entry to RUN or STEP. It sets after the first cycle in which `cpu_en`=1, so resuming or stepping from a breakpoint PC does not re-trigger immediately.
- In STEP the compare is ignored.

`cpu_en` behaviour:
- `cpu_en` = (state is RUN or STEP) AND NOT match.
- The match term is combinational, so the pipeline freezes with `brk_pc` held in IF in the same cycle as the match.

Interrupt pulse:
- An irq edge sets `pending`.
- `irq_pulse` = `pending & cpu_en`. When `irq_pulse` is high, `pending` clears on the next edge.
- Edges that arrive while `pending`=1 merge into one pulse.

Counters:
- `cycle_cnt` increments on every cycle with `cpu_en`=1.
- `step_cnt` increments on each STEP→HALT transition.

## Timing
- Reset values: state=HALT, `cpu_en`=0, `irq_pulse`=0, `halted`=1, `brk_hit`=0, both counters=0. Synchroniser flops, `pending` and `armed` are all 0.
- After reset release with `debug_en`=0: RUN is entered at the first edge, so `cpu_en`=1 from cycle 1.
- Step latency: the raw input rises before edge k; the synchronised edge is seen after edge k+SYNC_STAGES-1; state=STEP after edge k+SYNC_STAGES. `cpu_en` is then high for exactly `STEP_CYCLES` cycles, after which the state returns to HALT.
- A step edge that arrives while in STEP or RUN is dropped.

Simultaneous events:
- In HALT/BRK, `debug_en`=0 together with a step edge → RUN wins.
- In RUN, a breakpoint match together with `debug_en` rising → BRK wins.

Reset mid-operation:
- Reset during STEP aborts the step immediately (asynchronous): state=HALT, and `step_cnt` is not incremented.
- Reset with `pending`=1 drops the interrupt.

## Structure
- Shared package `mips_dbg_pkg` holds the state encoding constants (`ST_RUN`, `ST_HALT`, `ST_STEP`, `ST_BRK`). The VGA debug view decodes `state` with the same package.
- Sub-module `sync_edge` (synchroniser plus rising-edge detect, parameterised by `SYNC_STAGES`) is instantiated twice, once per button.
- FSM, step counter, `armed`, `pending` and the two statistics counters live in the top of this block.

## Test plan
- **Reset/run:** reset with `debug_en`=0, release → `cpu_en`=1 from cycle 1; after 100 cycles `cycle_cnt`=100, state=0.
- **Single step:** `debug_en`=1, `STEP_CYCLES`=1; pulse `step_btn` for 5 cycles → exactly one `cpu_en` cycle at edge k+2; `step_cnt`=1; state returns to HALT.
- **Breakpoint:** `brk_en`=1, `brk_pc`=0x0000_0010; RUN with `if_pc` advancing by 4 → `cpu_en`=0 in the cycle `if_pc`=0x10; `brk_hit`=1 from the next cycle. A step edge then gives one enabled cycle with no re-trigger, and the state ends in HALT.
- **Interrupt while halted:** two `irq_btn` pulses while in HALT → `irq_pulse`=0 throughout. The next step produces a single `irq_pulse` in the first `cpu_en` cycle.
- **Conflict:** in BRK, drop `debug_en` in the same cycle as a step edge → state=RUN; `step_cnt` unchanged.
- **Reset mid-step:** `STEP_CYCLES`=8; assert `rst` at step cycle 3 → `cpu_en`=0 immediately, `step_cnt`=0, state=HALT.
